// File: rtl/onchip_sram_dp_pipelined.sv
// Parametrised single-clock true-dual-port SRAM with two Avalon-MM pipelined
// slaves (s1 = host, s2 = NPU). It uses write-first forwarding on same-address
// collisions, gives s1 priority on overlapping byte lanes, and clears the
// whole array to INIT_VALUE after reset.
module onchip_sram_dp_pipelined #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 15,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    input  logic [ADDR_W-1:0]     address2,
    input  logic [DATA_W/8-1:0]   byteenable2,
    input  logic                  chipselect2,
    input  logic                  read2,
    input  logic                  write2,
    input  logic [DATA_W-1:0]     writedata2,
    output logic [DATA_W-1:0]     readdata2,
    output logic                  readdatavalid2,
    output logic                  waitrequest2,
    output logic                  init_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W:0]   sweep_cnt;
    logic              init_we;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr1_p0, rd1_p0, wr2_p0, rd2_p0;
    logic [BE_W-1:0]   be2_at1, be1_at2;
    logic [DATA_W-1:0] word1_p0, word2_p0;

    // Replace the byte lanes selected by be with the corresponding lanes of new_word.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return r;
    endfunction

    // Request acceptance; a simultaneous read+write is treated as a write only.
    assign wr1_p0  = chipselect  & write  & ~waitrequest;
    assign rd1_p0  = chipselect  & read   & ~write  & ~waitrequest;
    assign wr2_p0  = chipselect2 & write2 & ~waitrequest2;
    assign rd2_p0  = chipselect2 & read2  & ~write2 & ~waitrequest2;
    assign init_we = (state == INIT) && (INIT_ON_RESET != 0) && !reset;

    // Post-write word at each port's address: s2 lanes applied first, s1 lanes on top.
    always_comb begin
        be2_at1  = (wr2_p0 && (address2 == address)) ? byteenable2 : '0;
        be1_at2  = (wr1_p0 && (address == address2)) ? byteenable  : '0;
        word1_p0 = lane_merge(lane_merge(mem[address], writedata2, be2_at1),
                              writedata, wr1_p0 ? byteenable : '0);
        word2_p0 = lane_merge(lane_merge(mem[address2], writedata2, wr2_p0 ? byteenable2 : '0),
                              writedata, be1_at2);
    end

    // Control FSM: clear sweep after reset, then serve both ports without stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            init_done    <= 1'b0;
            waitrequest  <= 1'b1;
            waitrequest2 <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (INIT_ON_RESET == 0 || sweep_cnt == LAST_WORD) begin
                        state        <= RUN;
                        init_done    <= 1'b1;
                        waitrequest  <= 1'b0;
                        waitrequest2 <= 1'b0;
                    end
                    sweep_cnt <= sweep_cnt + (ADDR_W + 1)'(1);
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Array update; both ports store the fully merged word so same-address writes agree.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[sweep_cnt[ADDR_W-1:0]] <= INIT_VALUE;
        end else begin
            if (wr2_p0) mem[address2] <= word2_p0;
            if (wr1_p0) mem[address]  <= word1_p0;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            // ---- stage p0 -> output: read data registered straight onto the bus
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readdatavalid  <= 1'b0;
                    readdatavalid2 <= 1'b0;
                    readdata       <= '0;
                    readdata2      <= '0;
                end else begin
                    readdatavalid  <= rd1_p0;
                    readdatavalid2 <= rd2_p0;
                    if (rd1_p0) readdata  <= word1_p0;
                    if (rd2_p0) readdata2 <= word2_p0;
                end
            end
        end else begin : g_lat2
            logic              vld1_p1, vld2_p1;
            logic [DATA_W-1:0] data1_p1, data2_p1;

            // ---- stage p0 -> p1: valid flags, cancelled by reset
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld1_p1 <= 1'b0;
                    vld2_p1 <= 1'b0;
                end else begin
                    vld1_p1 <= rd1_p0;
                    vld2_p1 <= rd2_p0;
                end
            end

            // ---- stage p0 -> p1: data, no reset needed
            always_ff @(posedge clk) begin
                if (rd1_p0) data1_p1 <= word1_p0;
                if (rd2_p0) data2_p1 <= word2_p0;
            end

            // ---- stage p1 -> output: extra output register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readdatavalid  <= 1'b0;
                    readdatavalid2 <= 1'b0;
                    readdata       <= '0;
                    readdata2      <= '0;
                end else begin
                    readdatavalid  <= vld1_p1;
                    readdatavalid2 <= vld2_p1;
                    if (vld1_p1) readdata  <= data1_p1;
                    if (vld2_p1) readdata2 <= data2_p1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_onchip_sram_dp_pipelined.sv
// Bench for onchip_sram_dp_pipelined: two instances (read latency 1 and 2) share the
// same stimulus and are compared every cycle against a word-level memory model.
module tb_onchip_sram_dp_pipelined;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] a1, a2;
    logic [1:0]    be1, be2;
    logic          cs1, rd1, wr1, cs2, rd2, wr2;
    logic [DW-1:0] wd1, wd2;

    logic [DW-1:0] rdata_l1, rdata2_l1, rdata_l2, rdata2_l2;
    logic rvld_l1, rvld2_l1, wait_l1, wait2_l1, done_l1;
    logic rvld_l2, rvld2_l2, wait_l2, wait2_l2, done_l2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onchip_sram_dp_pipelined #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1),
                               .INIT_ON_RESET(1), .INIT_VALUE(16'h0000)) u_l1 (
        .clk(clk), .reset(rst),
        .address(a1), .byteenable(be1), .chipselect(cs1), .read(rd1), .write(wr1),
        .writedata(wd1), .readdata(rdata_l1), .readdatavalid(rvld_l1), .waitrequest(wait_l1),
        .address2(a2), .byteenable2(be2), .chipselect2(cs2), .read2(rd2), .write2(wr2),
        .writedata2(wd2), .readdata2(rdata2_l1), .readdatavalid2(rvld2_l1), .waitrequest2(wait2_l1),
        .init_done(done_l1));

    onchip_sram_dp_pipelined #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2),
                               .INIT_ON_RESET(1), .INIT_VALUE(16'h0000)) u_l2 (
        .clk(clk), .reset(rst),
        .address(a1), .byteenable(be1), .chipselect(cs1), .read(rd1), .write(wr1),
        .writedata(wd1), .readdata(rdata_l2), .readdatavalid(rvld_l2), .waitrequest(wait_l2),
        .address2(a2), .byteenable2(be2), .chipselect2(cs2), .read2(rd2), .write2(wr2),
        .writedata2(wd2), .readdata2(rdata2_l2), .readdatavalid2(rvld2_l2), .waitrequest2(wait2_l2),
        .init_done(done_l2));

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_run;
    int            m_cnt;
    bit            cur_v [2];
    bit            prev_v [2];
    logic [DW-1:0] cur_d [2];
    logic [DW-1:0] prev_d [2];
    logic [DW-1:0] exp_rd [2][2];   // [latency-1][port]

    function automatic logic [DW-1:0] apply_lanes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [1:0] be);
        logic [DW-1:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_clear();
        m_run = 0;
        m_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            cur_v[p] = 0; prev_v[p] = 0; cur_d[p] = '0; prev_d[p] = '0;
            exp_rd[0][p] = '0; exp_rd[1][p] = '0;
        end
    endtask

    task automatic model_edge();
        bit w1, r1, w2, r2;
        if (rst) begin
            model_clear();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            prev_v[p] = cur_v[p]; prev_d[p] = cur_d[p]; cur_v[p] = 0;
        end
        if (!m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_run = 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            w1 = cs1 && wr1; r1 = cs1 && rd1 && !wr1;
            w2 = cs2 && wr2; r2 = cs2 && rd2 && !wr2;
            if (w2) m_mem[a2] = apply_lanes(m_mem[a2], wd2, be2);
            if (w1) m_mem[a1] = apply_lanes(m_mem[a1], wd1, be1);
            if (r1) begin cur_v[0] = 1; cur_d[0] = m_mem[a1]; end
            if (r2) begin cur_v[1] = 1; cur_d[1] = m_mem[a2]; end
        end
        for (int p = 0; p < 2; p++) begin
            if (cur_v[p])  exp_rd[0][p] = cur_d[p];
            if (prev_v[p]) exp_rd[1][p] = prev_d[p];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rdv_l1",   32'(rvld_l1),   32'(cur_v[0]));
        chk("rdv2_l1",  32'(rvld2_l1),  32'(cur_v[1]));
        chk("rd_l1",    32'(rdata_l1),  32'(exp_rd[0][0]));
        chk("rd2_l1",   32'(rdata2_l1), 32'(exp_rd[0][1]));
        chk("rdv_l2",   32'(rvld_l2),   32'(prev_v[0]));
        chk("rdv2_l2",  32'(rvld2_l2),  32'(prev_v[1]));
        chk("rd_l2",    32'(rdata_l2),  32'(exp_rd[1][0]));
        chk("rd2_l2",   32'(rdata2_l2), 32'(exp_rd[1][1]));
        chk("wait_l1",  32'(wait_l1),   32'(!m_run));
        chk("wait2_l1", 32'(wait2_l1),  32'(!m_run));
        chk("wait_l2",  32'(wait_l2),   32'(!m_run));
        chk("wait2_l2", 32'(wait2_l2),  32'(!m_run));
        chk("done_l1",  32'(done_l1),   32'(m_run));
        chk("done_l2",  32'(done_l2),   32'(m_run));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cs1 = 0; rd1 = 0; wr1 = 0; cs2 = 0; rd2 = 0; wr2 = 0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!done_l1 && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit w1; bit r1; logic [AW-1:0] a1; logic [1:0] be1; logic [DW-1:0] wd1;
        bit w2; bit r2; logic [AW-1:0] a2; logic [1:0] be2; logic [DW-1:0] wd2;
        logic [DW-1:0] exp1; logic [DW-1:0] exp2;
    } vec_t;

    function automatic vec_t mk(bit w1, bit r1, logic [AW-1:0] a1, logic [1:0] be1, logic [DW-1:0] wd1,
                                bit w2, bit r2, logic [AW-1:0] a2, logic [1:0] be2, logic [DW-1:0] wd2,
                                logic [DW-1:0] exp1, logic [DW-1:0] exp2);
        vec_t v;
        v.w1 = w1; v.r1 = r1; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
        v.w2 = w2; v.r2 = r2; v.a2 = a2; v.be2 = be2; v.wd2 = wd2;
        v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        idle();
        a1 = '0; a2 = '0; be1 = '0; be2 = '0; wd1 = '0; wd2 = '0;
        model_clear();

        // Reset state held over a few edges
        rst = 1;
        repeat (3) tick();
        chk("reset_wait", 32'(wait_l1), 32'd1);
        chk("reset_done", 32'(done_l2), 32'd0);
        rst = 0;
        wait_init("init_cycles");

        //           w1 r1 a1 be1    wd1        w2 r2 a2 be2    wd2        exp1      exp2
        vt[0]  = mk(0, 0, 0, 2'b00, 16'h0000, 0, 1, 9, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        vt[1]  = mk(1, 0, 5, 2'b11, 16'hBEEF, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        vt[2]  = mk(0, 0, 0, 2'b00, 16'h0000, 0, 1, 5, 2'b00, 16'h0000, 16'h0000, 16'hBEEF);
        vt[3]  = mk(1, 0, 5, 2'b01, 16'h1234, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        vt[4]  = mk(0, 1, 5, 2'b00, 16'h0000, 0, 0, 0, 2'b00, 16'h0000, 16'hBE34, 16'h0000);
        vt[5]  = mk(1, 0, 7, 2'b11, 16'h1111, 1, 0, 7, 2'b11, 16'h2222, 16'h0000, 16'h0000);
        vt[6]  = mk(0, 0, 0, 2'b00, 16'h0000, 0, 1, 7, 2'b00, 16'h0000, 16'h0000, 16'h1111);
        vt[7]  = mk(1, 0, 7, 2'b01, 16'h1111, 1, 0, 7, 2'b11, 16'h2222, 16'h0000, 16'h0000);
        vt[8]  = mk(0, 1, 7, 2'b00, 16'h0000, 0, 0, 0, 2'b00, 16'h0000, 16'h2211, 16'h0000);
        vt[9]  = mk(1, 0, 3, 2'b11, 16'h5555, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        vt[10] = mk(1, 0, 3, 2'b11, 16'hAAAA, 0, 1, 3, 2'b00, 16'h0000, 16'h0000, 16'hAAAA);
        vt[11] = mk(0, 1, 3, 2'b00, 16'h0000, 0, 1, 3, 2'b00, 16'h0000, 16'hAAAA, 16'hAAAA);
        vt[12] = mk(1, 0, 3, 2'b10, 16'h00FF, 0, 1, 3, 2'b00, 16'h0000, 16'h0000, 16'h00AA);
        vt[13] = mk(1, 1, 9, 2'b11, 16'h7777, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        vt[14] = mk(0, 0, 0, 2'b00, 16'h0000, 0, 1, 9, 2'b00, 16'h0000, 16'h0000, 16'h7777);

        for (int i = 0; i < 15; i++) begin
            cs1 = vt[i].w1 | vt[i].r1; wr1 = vt[i].w1; rd1 = vt[i].r1;
            a1 = vt[i].a1; be1 = vt[i].be1; wd1 = vt[i].wd1;
            cs2 = vt[i].w2 | vt[i].r2; wr2 = vt[i].w2; rd2 = vt[i].r2;
            a2 = vt[i].a2; be2 = vt[i].be2; wd2 = vt[i].wd2;
            tick();
            idle();
            tick();
            tick();
            if (vt[i].r1 && !vt[i].w1) begin
                chk($sformatf("vec%0d_rd_l1", i), 32'(rdata_l1), 32'(vt[i].exp1));
                chk($sformatf("vec%0d_rd_l2", i), 32'(rdata_l2), 32'(vt[i].exp1));
            end
            if (vt[i].r2 && !vt[i].w2) begin
                chk($sformatf("vec%0d_rd2_l1", i), 32'(rdata2_l1), 32'(vt[i].exp2));
                chk($sformatf("vec%0d_rd2_l2", i), 32'(rdata2_l2), 32'(vt[i].exp2));
            end
        end

        // Exact read latency: one cycle for u_l1, two for u_l2
        cs2 = 1; rd2 = 1; a2 = 5;
        tick();
        idle();
        chk("lat1_vld", 32'(rvld2_l1), 32'd1);
        chk("lat2_early", 32'(rvld2_l2), 32'd0);
        chk("lat1_data", 32'(rdata2_l1), 32'h0000BE34);
        tick();
        chk("lat1_pulse", 32'(rvld2_l1), 32'd0);
        chk("lat2_vld", 32'(rvld2_l2), 32'd1);
        chk("lat2_data", 32'(rdata2_l2), 32'h0000BE34);
        tick();

        // Back-to-back reads interrupted by reset after the second valid of u_l1
        cs1 = 1; rd1 = 1; a1 = 5;
        tick();
        a1 = 7;
        tick();
        chk("b2b_second_vld", 32'(rvld_l1), 32'd1);
        a1 = 3;
        rst = 1;
        model_clear();
        #1;
        check_outputs();
        tick();
        a1 = 9;
        tick();
        idle();
        rst = 0;
        wait_init("reinit_cycles");
        cs1 = 1; rd1 = 1; a1 = 5; cs2 = 1; rd2 = 1; a2 = 3;
        tick();
        idle();
        tick();
        tick();
        chk("after_sweep_rd", 32'(rdata_l2), 32'd0);
        chk("after_sweep_rd2", 32'(rdata2_l1), 32'd0);

        // Randomized traffic with forced address collisions
        for (int c = 0; c < 600; c++) begin
            cs1 = ($urandom_range(3) != 0); rd1 = $urandom_range(1); wr1 = $urandom_range(1);
            cs2 = ($urandom_range(3) != 0); rd2 = $urandom_range(1); wr2 = $urandom_range(1);
            a1  = AW'($urandom_range(DEPTH - 1));
            a2  = ($urandom_range(2) == 0) ? a1 : AW'($urandom_range(DEPTH - 1));
            be1 = 2'($urandom_range(3)); be2 = 2'($urandom_range(3));
            wd1 = 16'($urandom); wd2 = 16'($urandom);
            if (c == 300) begin
                rst = 1;
                model_clear();
            end
            if (c == 302) rst = 0;
            tick();
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
